// File: rtl/uart_rx_fifo_if.sv
// Byte stream between the UART receiver, the receive FIFO and its consumer.
// The FIFO takes the slave view. The producer/consumer side takes the master view.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_error;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output rx_data, rx_ready, rx_error, out_ready,
    input  out_data, out_err, out_valid
  );

  modport slave (
    input  rx_data, rx_ready, rx_error, out_ready,
    output out_data, out_err, out_valid
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with a first-word-fall-through head; a written byte is visible 1 cycle later.
// There is no backpressure to rx: a byte arriving while full with no read is dropped and counted.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_fifo_if.slave        bus,
  input  logic                 flush,
  input  logic                 clr_ovf,
  output logic [AW:0]          count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          rd_ev, wr_ev, drop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    rd_ev = (count_q != '0) && bus.out_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts the byte.
    wr_ev = bus.rx_ready && ((count_q != FULL_CNT) || rd_ev) && !flush;
    drop  = bus.rx_ready && (count_q == FULL_CNT) && !rd_ev && !flush;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ev) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ev) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_ev, rd_ev})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // A drop in the clearing cycle counts as the first drop after the clear.
    if (clr_ovf) begin
      ovf_d      = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ev) mem_q[wr_ptr_q] <= {bus.rx_error, bus.rx_data};
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_data  = head[7:0];
  assign bus.out_err   = head[8];
  assign bus.out_valid = (count_q != '0);

  assign count    = count_q;
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign overflow = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=8): fall-through head, fill/drop, wrap with error tags,
// drop-counter saturation and clear, flush, and asynchronous reset mid-stream.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       clr_ovf;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    bus.rx_data  = d;
    bus.rx_error = e;
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int sent;
    int recv;
    int max_cnt;
    logic [8:0] exp9;

    rst_n        = 1'b0;
    flush        = 1'b0;
    clr_ovf      = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_error = 1'b0;
    bus.rx_ready = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    check("reset_count", 32'(count), 0);
    check("reset_empty", 32'(empty), 1);
    check("reset_full", 32'(full), 0);
    check("reset_valid", 32'(bus.out_valid), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_drop_cnt", 32'(drop_cnt), 0);
    #10 rst_n = 1'b1;
    tick();

    // Single byte, visible one cycle after the write edge.
    push(8'hA5, 1'b0);
    check("single_valid", 32'(bus.out_valid), 1);
    check("single_data", 32'(bus.out_data), 'hA5);
    check("single_err", 32'(bus.out_err), 0);
    check("single_count", 32'(count), 1);
    pop();
    check("single_empty_after_read", 32'(empty), 1);

    // Write into empty FIFO with out_ready high: only the write happens.
    bus.out_ready = 1'b1;
    push(8'h3C, 1'b1);
    bus.out_ready = 1'b0;
    check("empty_rw_count", 32'(count), 1);
    check("empty_rw_err", 32'(bus.out_err), 1);
    pop();
    check("empty_rw_drained", 32'(empty), 1);

    // Fill, then drop one byte.
    for (int i = 0; i < 8; i++) push(8'(i), 1'b0);
    check("fill_full", 32'(full), 1);
    check("fill_overflow_clear", 32'(overflow), 0);
    push(8'h08, 1'b0);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_cnt_one", 32'(drop_cnt), 1);
    check("drop_count_stays", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      check("fill_read_order", 32'(bus.out_data), 32'(i));
      pop();
    end
    check("fill_drained", 32'(empty), 1);

    // Full with simultaneous read and write: accepted, no drop.
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i), 1'b0);
    bus.out_ready = 1'b1;
    push(8'h55, 1'b0);
    bus.out_ready = 1'b0;
    check("full_rw_count", 32'(count), 8);
    check("full_rw_no_drop", 32'(drop_cnt), 1);
    for (int i = 0; i < 8; i++) begin
      check("full_rw_order", 32'(bus.out_data), (i < 7) ? 32'('h11 + i) : 'h55);
      pop();
    end
    check("full_rw_drained", 32'(empty), 1);

    // Streaming with wrap, error tags every third byte, toggling consumer.
    sent = 0;
    recv = 0;
    max_cnt = 0;
    for (int cyc = 0; cyc < 200 && recv < 20; cyc++) begin
      bus.rx_ready  = (sent < 20) && (cyc % 3 != 2);
      bus.rx_data   = 8'(8'h80 + sent);
      bus.rx_error  = (sent % 3 == 2);
      bus.out_ready = (cyc % 2 == 1);
      if (bus.out_valid && bus.out_ready) begin
        exp9 = {(recv % 3 == 2), 8'(8'h80 + recv)};
        check("stream_byte", 32'({bus.out_err, bus.out_data}), 32'(exp9));
        recv++;
      end
      if (bus.rx_ready) sent++;
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    bus.rx_ready  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_all_received", 32'(recv), 20);
    check("stream_max_count_le_8", 32'(max_cnt <= 8), 1);
    check("stream_no_drop", 32'(drop_cnt), 1);
    for (int i = 0; i < 20 && bus.out_valid; i++) pop();
    check("stream_drained", 32'(empty), 1);

    // Saturating drop counter, then clear coinciding with a drop.
    for (int i = 0; i < 8; i++) push(8'(8'hC0 + i), 1'b0);
    bus.rx_ready = 1'b1;
    repeat (300) tick();
    bus.rx_ready = 1'b0;
    check("sat_drop_cnt", 32'(drop_cnt), 255);
    check("sat_overflow", 32'(overflow), 1);
    check("sat_count", 32'(count), 8);
    clr_ovf = 1'b1;
    push(8'hEE, 1'b0);
    clr_ovf = 1'b0;
    check("clr_with_drop_overflow", 32'(overflow), 1);
    check("clr_with_drop_cnt", 32'(drop_cnt), 1);
    check("clr_head_kept", 32'(bus.out_data), 'hC0);

    // Flush with a same-cycle write: discarded, not counted as drop.
    repeat (3) pop();
    check("pre_flush_count", 32'(count), 5);
    flush = 1'b1;
    push(8'h99, 1'b0);
    flush = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_valid", 32'(bus.out_valid), 0);
    check("flush_drop_cnt_kept", 32'(drop_cnt), 1);
    check("flush_overflow_kept", 32'(overflow), 1);
    push(8'h11, 1'b0);
    check("post_flush_data", 32'(bus.out_data), 'h11);

    // Asynchronous reset mid-stream.
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    check("pre_reset_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_full", 32'(full), 0);
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_drop_cnt", 32'(drop_cnt), 0);
    #2 rst_n = 1'b1;
    tick();
    push(8'h42, 1'b1);
    check("post_reset_data", 32'(bus.out_data), 'h42);
    check("post_reset_err", 32'(bus.out_err), 1);
    check("post_reset_count", 32'(count), 1);

    // Plain clear after a drop.
    for (int i = 0; i < 7; i++) push(8'(i), 1'b0);
    push(8'hF0, 1'b0);
    check("late_drop_overflow", 32'(overflow), 1);
    check("late_drop_cnt", 32'(drop_cnt), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_overflow", 32'(overflow), 0);
    check("clr_drop_cnt", 32'(drop_cnt), 0);
    check("clr_count_kept", 32'(count), 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO entry count; SHALL be a power of two, 2..64.
REQ-002 Parameter AW, default $clog2(DEPTH), meaning pointer width; SHALL be derived only, never overridden.
REQ-003 clk  in  1  single clock; every flop is rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 rx_data  in  8  received byte from the UART receiver.
REQ-006 rx_ready  in  1  one-cycle pulse; rx_data and rx_error are valid in that cycle.
REQ-007 rx_error  in  1  frame or parity error for the byte.
REQ-008 out_data  out  8  head-entry byte.
REQ-009 out_err  out  1  head-entry error tag.
REQ-010 out_valid  out  1  head entry present.
REQ-011 out_ready  in  1  consumer accepts the head entry.
REQ-012 flush  in  1  synchronous FIFO empty request.
REQ-013 clr_ovf  in  1  clears overflow and drop_cnt.
REQ-014 count  out  AW+1  current occupancy.
REQ-015 full  out  1  count == DEPTH.
REQ-016 empty  out  1  count == 0.
REQ-017 overflow  out  1  sticky flag: at least one byte was dropped.
REQ-018 drop_cnt  out  8  number of dropped bytes, saturating.

Function
REQ-019 Each entry SHALL store 9 bits: {rx_error, rx_data}.
REQ-020 Write event: rx_ready=1 and a slot is available. Data is written at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-021 Read event: out_valid=1 and out_ready=1. rd_ptr increments modulo DEPTH.
REQ-022 Read is first-word-fall-through. out_data/out_err SHALL show the entry at rd_ptr with no extra latency; out_valid = ~empty.
REQ-023 Write-to-visible latency SHALL be 1 cycle: a byte written into an empty FIFO at edge N gives out_valid=1 after edge N.
REQ-024 count update per cycle: write only -> +1; read only -> -1; both -> unchanged; neither -> unchanged.
REQ-025 Full with rx_ready=1 and read event in the same cycle: the write SHALL be accepted; count stays DEPTH; no drop.
REQ-026 Full with rx_ready=1 and no read event: the byte SHALL be dropped; overflow <= 1; drop_cnt increments, saturating at 255.
REQ-027 Empty with rx_ready=1 and out_ready=1: only the write occurs; count -> 1.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or duplicate.
REQ-029 out_ready while empty SHALL have no effect; the pointers never underflow.
REQ-030 flush=1 SHALL set wr_ptr, rd_ptr and count to 0 at the next edge. flush overrides a same-cycle write or read; that rx_ready byte is discarded and not counted as a drop.
REQ-031 flush SHALL NOT change overflow or drop_cnt.
REQ-032 clr_ovf=1 clears overflow and drop_cnt at the next edge. If a drop occurs in the same cycle, the result SHALL be overflow=1 and drop_cnt=1.
REQ-033 Storage RAM contents need no reset; out_data and out_err are don't-care while out_valid=0.
REQ-034 rx_ready held high for several cycles SHALL be treated as one write per cycle.

Reset
REQ-035 Asserting rst_n=0 at any time, including mid-stream, SHALL force immediately: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, out_valid=0, overflow=0, drop_cnt=0.
REQ-036 After rst_n deasserts, the first rx_ready pulse SHALL be accepted normally.

Verification
REQ-037 Single byte: rx_ready pulse with 0xA5 and rx_error=0 -> next cycle out_valid=1, out_data=0xA5, out_err=0, count=1. Then out_ready=1 for one cycle -> empty=1.
REQ-038 Fill and overflow (DEPTH=8): write 0x00..0x07, then 0x08 with no read -> full=1, overflow=1, drop_cnt=1. Reads return 0x00..0x07 in order; 0x08 is never seen.
REQ-039 Full with simultaneous read and write: at full, pulse rx_ready with 0x55 while out_ready=1 -> count stays 8, no drop. 0x55 is read 8th after the current head.
REQ-040 Wrap and error tag: stream 20 bytes, every third with rx_error=1, consumer toggling out_ready -> all 20 bytes are received in order with matching out_err; count never exceeds 8.
REQ-041 Saturation and clear: cause 300 drops -> drop_cnt=255. Then assert clr_ovf together with one more drop -> overflow=1, drop_cnt=1.
REQ-042 Flush and reset mid-operation: with count=5, assert flush and rx_ready together -> count=0 and drop_cnt unchanged. Then with count=3, pulse rst_n low -> all outputs reach their REQ-035 values asynchronously.
